// File: rtl/cell_core_mc.sv
// Per-cell execution core: one broadcast 16-bit instruction per accepted issue, single-cycle
// ALU ops plus an iterative shift-add multiplier behind a valid/ready issue handshake.

module cell_core_alu #(
  parameter int REGISTER_LENGTH = 8
) (
  input  logic [3:0]                 opcode,
  input  logic [REGISTER_LENGTH-1:0] a,
  input  logic [REGISTER_LENGTH-1:0] b,
  input  logic [7:0]                 imm,
  output logic [REGISTER_LENGTH-1:0] result,
  output logic                       we
);
  localparam int RL = REGISTER_LENGTH;

  // 1 MOV, 2 LDI, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 MUL, 9 SHL, 10 SHR; others are NOPs
  always_comb begin
    result = '0;
    we     = 1'b1;
    case (opcode)
      4'h1:    result = a;
      4'h2:    result = RL'(imm);
      4'h3:    result = a + b;
      4'h4:    result = a - b;
      4'h5:    result = a & b;
      4'h6:    result = a | b;
      4'h7:    result = a ^ b;
      4'h8:    result = a * b;
      4'h9:    result = a << b;
      4'hA:    result = a >> b;
      default: we = 1'b0;
    endcase
  end
endmodule

module cell_core_mc #(
  parameter int X               = 0,
  parameter int Y               = 0,
  parameter int REGISTER_LENGTH = 8,
  parameter int NUM_REGS        = 8,
  parameter int MUL_ENABLE      = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [15:0]                instruction,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [REGISTER_LENGTH-1:0] i01,
  input  logic [REGISTER_LENGTH-1:0] i10,
  input  logic [REGISTER_LENGTH-1:0] i12,
  input  logic [REGISTER_LENGTH-1:0] i21,
  input  logic [REGISTER_LENGTH-1:0] i11,
  output logic [REGISTER_LENGTH-1:0] nextState,
  output logic                       state_we,
  output logic [REGISTER_LENGTH-1:0] nextVideo,
  output logic                       busy
);
  localparam int RL = REGISTER_LENGTH;
  localparam int CW = $clog2(RL + 1);
  // REG_VIDEO shares the REG_ZERO code: reads give 0, writes land in nextVideo
  localparam int REG_MY = 0, REG_VIDEO = 9, REG_X = 10, REG_Y = 11;
  localparam int REG_XMINUS = 12, REG_XPLUS = 13, REG_YMINUS = 14, REG_YPLUS = 15;
  localparam logic [3:0]    OP_MUL = 4'h8;
  localparam logic [RL-1:0] X_V = RL'(X);
  localparam logic [RL-1:0] Y_V = RL'(Y);

  typedef struct packed {
    logic          en;
    logic [3:0]    tgt;
    logic [RL-1:0] val;
  } wb_t;

  logic [NUM_REGS:1][RL-1:0] regs_q, regs_d;
  logic [RL-1:0]             next_state_q, next_state_d, next_video_q, next_video_d;
  logic [RL-1:0]             mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, acc_step;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [3:0]                tgt_q, tgt_d;
  logic                      busy_q, busy_d, state_we_q, state_we_d;
  logic [15:0][RL-1:0]       src;
  logic [RL-1:0]             op_a, op_b, alu_res;
  logic                      alu_we;
  wb_t                       wb;

  always_comb begin
    src = '0;
    src[REG_MY] = i11;
    for (int k = 1; k <= NUM_REGS; k++) src[k] = regs_q[k];
    src[REG_X]      = X_V;
    src[REG_Y]      = Y_V;
    src[REG_XMINUS] = i10;
    src[REG_XPLUS]  = i12;
    src[REG_YMINUS] = i01;
    src[REG_YPLUS]  = i21;
  end

  assign op_a = src[instruction[7:4]];
  assign op_b = src[instruction[3:0]];

  cell_core_alu #(.REGISTER_LENGTH(RL)) u_alu (
    .opcode (instruction[15:12]),
    .a      (op_a),
    .b      (op_b),
    .imm    (instruction[7:0]),
    .result (alu_res),
    .we     (alu_we)
  );

  assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;

  always_comb begin
    regs_d       = regs_q;
    next_state_d = next_state_q;
    next_video_d = next_video_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    tgt_d        = tgt_q;
    busy_d       = busy_q;
    state_we_d   = 1'b0;
    wb           = '0;
    if (busy_q) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      // last iteration writes back on the same edge that drops busy
      if (cnt_q == CW'(RL - 1)) begin
        busy_d = 1'b0;
        cnt_d  = '0;
        wb     = '{en: 1'b1, tgt: tgt_q, val: acc_step};
      end
    end else if (issue_valid) begin
      if (MUL_ENABLE != 0 && instruction[15:12] == OP_MUL) begin
        busy_d   = 1'b1;
        mcand_d  = op_a;
        mplier_d = op_b;
        acc_d    = '0;
        cnt_d    = '0;
        tgt_d    = instruction[11:8];
      end else if (alu_we) begin
        wb = '{en: 1'b1, tgt: instruction[11:8], val: alu_res};
      end
    end
    if (wb.en) begin
      if (wb.tgt == 4'(REG_MY)) begin
        next_state_d = wb.val;
        state_we_d   = 1'b1;
      end
      if (wb.tgt == 4'(REG_VIDEO)) next_video_d = wb.val;
      for (int k = 1; k <= NUM_REGS; k++)
        if (wb.tgt == 4'(k)) regs_d[k] = wb.val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q       <= '0;
      next_state_q <= '0;
      next_video_q <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      tgt_q        <= '0;
      busy_q       <= 1'b0;
      state_we_q   <= 1'b0;
    end else begin
      regs_q       <= regs_d;
      next_state_q <= next_state_d;
      next_video_q <= next_video_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      tgt_q        <= tgt_d;
      busy_q       <= busy_d;
      state_we_q   <= state_we_d;
    end
  end

  assign nextState   = next_state_q;
  assign nextVideo   = next_video_q;
  assign state_we    = state_we_q;
  assign busy        = busy_q;
  assign issue_ready = ~busy_q;
endmodule
